// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: 1-cycle imem, stall skid hold, branch redirect.
// Define FETCH_CTRL_PERF_EN to enable the fetch/squash performance counters.
`timescale 1ns/1ps
module fetch_ctrl #(
    parameter int              ADDR     = 32,
    parameter int              INST     = 32,
    parameter logic [ADDR-1:0] RESET_PC = '0,
    parameter logic [ADDR-1:0] INC      = {{(ADDR-1){1'b0}}, 1'b1}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [ADDR-1:0] baddr_i,
    output logic            imem_req_o,
    output logic [ADDR-1:0] imem_addr_o,
    input  logic [INST-1:0] imem_data_i,
    output logic            v_o,
    output logic [INST-1:0] inst_o,
    output logic [ADDR-1:0] pc_o,
    output logic [31:0]     perf_fetch_o,
    output logic [31:0]     perf_squash_o
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t          state_q, state_d;
    logic [ADDR-1:0] pc_q, pc_d;
    logic [ADDR-1:0] paddr_q, paddr_d;
    logic [ADDR-1:0] hold_pc_q, hold_pc_d;
    logic [INST-1:0] hold_inst_q, hold_inst_d;
    logic            pend_q, pend_d;
    logic            hold_v_q, hold_v_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            paddr_q     <= '0;
            hold_pc_q   <= '0;
            hold_inst_q <= '0;
            pend_q      <= 1'b0;
            hold_v_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            paddr_q     <= paddr_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
            pend_q      <= pend_d;
            hold_v_q    <= hold_v_d;
        end
    end

    assign imem_addr_o = pc_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        paddr_d     = paddr_q;
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;
        pend_d      = pend_q;
        hold_v_d    = hold_v_q;
        imem_req_o  = 1'b1;
        v_o         = 1'b0;
        inst_o      = '0;
        pc_o        = '0;
        unique case (state_q)
            IDLE: begin
                imem_req_o = 1'b0;
                state_d    = RUN;
                if (branch_i) pc_d = baddr_i;
            end
            RUN: begin
                v_o    = pend_q;
                inst_o = imem_data_i;
                pc_o   = paddr_q;
                if (!stall_i) begin
                    pc_d    = pc_q + INC;
                    paddr_d = pc_q;
                    pend_d  = 1'b1;
                end else begin
                    // Capture the in-flight word; pc_q already addresses the next one.
                    hold_inst_d = imem_data_i;
                    hold_pc_d   = paddr_q;
                    hold_v_d    = pend_q;
                    pend_d      = 1'b0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                v_o    = hold_v_q;
                inst_o = hold_inst_q;
                pc_o   = hold_pc_q;
                if (!stall_i) begin
                    pc_d     = pc_q + INC;
                    paddr_d  = pc_q;
                    pend_d   = 1'b1;
                    hold_v_d = 1'b0;
                    state_d  = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
        if (branch_i && state_q != IDLE) begin
            v_o      = 1'b0;
            pc_d     = baddr_i;
            pend_d   = 1'b0;
            hold_v_d = 1'b0;
            state_d  = RUN;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fetch_q, squash_q;
    logic        live;

    // Whether the slot a branch kills actually carried a valid instruction.
    always_comb begin
        live = 1'b0;
        unique case (state_q)
            RUN:     live = pend_q;
            HOLD:    live = hold_v_q;
            default: live = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_q  <= '0;
            squash_q <= '0;
        end else begin
            if (v_o && !stall_i && fetch_q != '1)
                fetch_q <= fetch_q + 32'd1;
            if (branch_i && live && squash_q != '1)
                squash_q <= squash_q + 32'd1;
        end
    end

    assign perf_fetch_o  = fetch_q;
    assign perf_squash_o = squash_q;
`else
    assign perf_fetch_o  = '0;
    assign perf_squash_o = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl: stream, branch, stall, reset, wrap.
`timescale 1ns/1ps
module tb_fetch_ctrl;

    typedef struct {
        logic        st;
        logic        br;
        logic [31:0] ba;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] baddr = '0;
    logic [31:0] imem_data = '0;
    logic        req, v;
    logic [31:0] addr, inst, pc, pf, ps;

    logic        w_zero = 1'b0;
    logic [3:0]  w_baddr = '0;
    logic [7:0]  w_data = '0;
    logic        w_req, w_v;
    logic [3:0]  w_addr, w_pc;
    logic [7:0]  w_inst;
    logic [31:0] w_pf, w_ps;

    int checks = 0;
    int failures = 0;
    vec_t tbl[28];

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .stall_i(stall), .branch_i(branch),
        .baddr_i(baddr), .imem_req_o(req), .imem_addr_o(addr),
        .imem_data_i(imem_data), .v_o(v), .inst_o(inst), .pc_o(pc),
        .perf_fetch_o(pf), .perf_squash_o(ps)
    );

    fetch_ctrl #(.ADDR(4), .INST(8), .RESET_PC(4'd13)) dut_w (
        .clk(clk), .rst(rst), .stall_i(w_zero), .branch_i(w_zero),
        .baddr_i(w_baddr), .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_data_i(w_data), .v_o(w_v), .inst_o(w_inst), .pc_o(w_pc),
        .perf_fetch_o(w_pf), .perf_squash_o(w_ps)
    );

    always #5 clk = ~clk;

    // Memory model: mem[a] = a + 0x100, one cycle read latency.
    always @(posedge clk) imem_data <= addr + 32'h100;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic br,
                                input logic [31:0] ba, input logic rq,
                                input logic [31:0] ad, input logic vv,
                                input logic [31:0] p, input logic [31:0] in);
        vec_t r;
        r.st = st; r.br = br; r.ba = ba; r.req = rq;
        r.addr = ad; r.v = vv; r.pc = p; r.inst = in;
        return r;
    endfunction

    task automatic apply(input int i);
        stall  = tbl[i].st;
        branch = tbl[i].br;
        baddr  = tbl[i].ba;
        #1;
        chk($sformatf("req[%0d]", i), {31'b0, req}, {31'b0, tbl[i].req});
        chk($sformatf("addr[%0d]", i), addr, tbl[i].addr);
        chk($sformatf("v[%0d]", i), {31'b0, v}, {31'b0, tbl[i].v});
        if (tbl[i].v) begin
            chk($sformatf("pc[%0d]", i), pc, tbl[i].pc);
            chk($sformatf("inst[%0d]", i), inst, tbl[i].inst);
        end else begin
            chk($sformatf("nox[%0d]", i),
                {30'b0, $isunknown(inst), $isunknown(pc)}, 32'd0);
        end
        if (i == 3) chk("wrap_addr15", {28'b0, w_addr}, 32'd15);
        if (i == 4) begin
            chk("wrap_addr0", {28'b0, w_addr}, 32'd0);
            chk("wrap_pc15", {28'b0, w_pc}, 32'd15);
        end
        if (i == 5) begin
            chk("wrap_v", {31'b0, w_v}, 32'd1);
            chk("wrap_pc0", {28'b0, w_pc}, 32'd0);
        end
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 0,     0, 32'h0,  0, 0, 0);
        tbl[1]  = mk(0, 0, 0,     1, 32'h0,  0, 0, 0);
        tbl[2]  = mk(0, 0, 0,     1, 32'h1,  1, 32'h0,  32'h100);
        tbl[3]  = mk(0, 0, 0,     1, 32'h2,  1, 32'h1,  32'h101);
        tbl[4]  = mk(0, 0, 0,     1, 32'h3,  1, 32'h2,  32'h102);
        tbl[5]  = mk(0, 0, 0,     1, 32'h4,  1, 32'h3,  32'h103);
        tbl[6]  = mk(0, 1, 32'h2, 1, 32'h5,  0, 0, 0);
        tbl[7]  = mk(0, 0, 0,     1, 32'h2,  0, 0, 0);
        tbl[8]  = mk(0, 0, 0,     1, 32'h3,  1, 32'h2,  32'h102);
        tbl[9]  = mk(1, 0, 0,     1, 32'h4,  1, 32'h3,  32'h103);
        tbl[10] = mk(1, 0, 0,     1, 32'h4,  1, 32'h3,  32'h103);
        tbl[11] = mk(1, 0, 0,     1, 32'h4,  1, 32'h3,  32'h103);
        tbl[12] = mk(0, 0, 0,     1, 32'h4,  1, 32'h3,  32'h103);
        tbl[13] = mk(0, 0, 0,     1, 32'h5,  1, 32'h4,  32'h104);
        tbl[14] = mk(0, 0, 0,     1, 32'h6,  1, 32'h5,  32'h105);
        tbl[15] = mk(1, 0, 0,     1, 32'h7,  1, 32'h6,  32'h106);
        tbl[16] = mk(1, 1, 32'h9, 1, 32'h7,  0, 0, 0);
        tbl[17] = mk(0, 0, 0,     1, 32'h9,  0, 0, 0);
        tbl[18] = mk(0, 0, 0,     1, 32'hA,  1, 32'h9,  32'h109);
        tbl[19] = mk(0, 1, 32'h20, 1, 32'hB, 0, 0, 0);
        tbl[20] = mk(1, 0, 0,     1, 32'h20, 0, 0, 0);
        tbl[21] = mk(0, 0, 0,     1, 32'h20, 0, 0, 0);
        tbl[22] = mk(0, 0, 0,     1, 32'h21, 1, 32'h20, 32'h120);
        tbl[23] = mk(0, 1, 32'h30, 1, 32'h22, 0, 0, 0);
        tbl[24] = mk(0, 1, 32'h40, 1, 32'h30, 0, 0, 0);
        tbl[25] = mk(0, 0, 0,     1, 32'h40, 0, 0, 0);
        tbl[26] = mk(0, 0, 0,     1, 32'h41, 1, 32'h40, 32'h140);
        tbl[27] = mk(0, 0, 0,     1, 32'h42, 1, 32'h41, 32'h141);

        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, req}, 32'd0);
        chk("rst_v", {31'b0, v}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_waddr", {28'b0, w_addr}, 32'd13);
        rst = 1'b0;

        for (int i = 0; i < 28; i++) begin
            apply(i);
            @(negedge clk);
        end

`ifdef FETCH_CTRL_PERF_EN
        chk("perf_fetch", pf, 32'd12);
        chk("perf_squash", ps, 32'd4);
`else
        chk("perf_fetch", pf, 32'd0);
        chk("perf_squash", ps, 32'd0);
`endif

        // Enter HOLD, then pulse reset between edges.
        stall = 1'b1;
        branch = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        stall = 1'b0;
        #1;
        chk("arst_v", {31'b0, v}, 32'd0);
        chk("arst_req", {31'b0, req}, 32'd0);
        chk("arst_addr", addr, 32'd0);
        chk("arst_pc", pc, 32'd0);
        chk("arst_inst", inst, 32'd0);
        chk("arst_perf", pf | ps, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_req", {31'b0, req}, 32'd0);
        chk("idle_v", {31'b0, v}, 32'd0);
        @(negedge clk);
        for (int i = 1; i < 6; i++) begin
            apply(i);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
